// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / exception controller
//
// Decides, every cycle, which pipeline registers hold (stall) and which are
// replaced by bubbles (flush), and whether fetch is redirected.
// Event priority in RUN: exception > interrupt > return-from-exception >
// taken branch / load hazard (the last two may combine). After a redirect
// caused by an exception, interrupt or return, the block spends one non-busy
// cycle in RECOVER, in which every event input is ignored.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_busy, mem_busy          bus access outstanding -> freeze everything
//   ld_hazard                  load-use hazard between ID and EX
//   br_taken, br_addr          taken branch resolved in ID and its target
//   mem_en, mem_pc             MEM stage valid flag and PC
//   mem_exp_code               MEM exception code (0 none, 1 = interrupt)
//   mem_exrt                   MEM instruction is return-from-exception
//   mem_int_en_wr/_val         MEM instruction writes interrupt enable
//   irq                        asynchronous external interrupt level
//   *_stall, *_flush           pipeline register hold / bubble controls
//   new_pc, new_pc_vld         combinational fetch redirect
//   epc, exp_cause, int_en     saved exception state (registered)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int                ADDR_W  = 30,
  parameter logic [ADDR_W-1:0] EXP_VEC = ADDR_W'(30'h0000_0100)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [2:0]        mem_exp_code,
  input  logic              mem_exrt,
  input  logic              mem_int_en_wr,
  input  logic              mem_int_en_val,
  input  logic              irq,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              new_pc_vld,
  output logic [ADDR_W-1:0] epc,
  output logic [2:0]        exp_cause,
  output logic              int_en
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_irq_meta;
  logic              r_irq_s;
  logic [ADDR_W-1:0] r_epc;
  logic [2:0]        r_exp_cause;
  logic              r_int_en;

  logic w_busy;
  logic w_exc;
  logic w_int;
  logic w_ret;
  logic w_trap;
  logic w_commit;

  assign w_busy   = if_busy | mem_busy;
  assign w_exc    = mem_en & (mem_exp_code != 3'd0);
  assign w_int    = mem_en & r_irq_s & r_int_en;
  assign w_ret    = mem_en & mem_exrt;
  assign w_trap   = w_exc | w_int;
  // Architectural state may only move in a non-busy RUN cycle.
  assign w_commit = (r_state == ST_RUN) & ~w_busy;

  assign epc       = r_epc;
  assign exp_cause = r_exp_cause;
  assign int_en    = r_int_en;

  // Two-flop irq synchronizer; keeps sampling even while the pipe is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_meta <= 1'b0;
      r_irq_s    <= 1'b0;
    end else begin
      r_irq_meta <= irq;
      r_irq_s    <= r_irq_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: RECOVER is entered on any redirecting trap/return and
  // is left after exactly one non-busy cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (~w_busy && (w_trap || w_ret)) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RECOVER: begin
        if (w_busy) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Saved exception state and interrupt enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc       <= {ADDR_W{1'b0}};
      r_exp_cause <= 3'd0;
      r_int_en    <= 1'b0;
    end else if (w_commit) begin
      if (w_exc) begin
        r_epc       <= mem_pc;
        r_exp_cause <= mem_exp_code;
        r_int_en    <= 1'b0;
      end else if (w_int) begin
        r_epc       <= mem_pc;
        r_exp_cause <= 3'd1;
        r_int_en    <= 1'b0;
      end else if (w_ret) begin
        r_int_en <= 1'b1;
      end else if (mem_en && mem_int_en_wr) begin
        r_int_en <= mem_int_en_val;
      end else begin
        r_int_en <= r_int_en;
      end
    end else begin
      r_epc       <= r_epc;
      r_exp_cause <= r_exp_cause;
      r_int_en    <= r_int_en;
    end
  end

  // Output decode: stall/flush controls and the combinational redirect.
  always_comb begin
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    mem_stall  = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    mem_flush  = 1'b0;
    new_pc     = {ADDR_W{1'b0}};
    new_pc_vld = 1'b0;
    if (reset) begin
      new_pc_vld = 1'b0;
    end else if (w_busy) begin
      // A bus access is outstanding: freeze the whole pipe, defer events.
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (r_state == ST_RUN) begin
      if (w_trap || w_ret) begin
        if_flush   = 1'b1;
        id_flush   = 1'b1;
        ex_flush   = 1'b1;
        mem_flush  = 1'b1;
        new_pc_vld = 1'b1;
        if (w_trap) begin
          new_pc = EXP_VEC;
        end else begin
          new_pc = r_epc;
        end
      end else begin
        if (br_taken) begin
          if_flush   = 1'b1;
          new_pc     = br_addr;
          new_pc_vld = 1'b1;
        end else begin
          new_pc_vld = 1'b0;
        end
        // Hold the consumer in ID and push a bubble into EX.
        if (ld_hazard) begin
          if_stall = 1'b1;
          id_flush = 1'b1;
        end else begin
          id_flush = 1'b0;
        end
      end
    end else begin
      // RECOVER: one quiet cycle while the redirected fetch gets going.
      new_pc_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a stimulus process drives one vector per
// cycle, asks a behavioural model for the expected response and queues it; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_pipe_ctrl;

  localparam int          AW = 30;
  localparam logic [29:0] EV = 30'h0000_0100;

  logic          clk = 1'b0;
  logic          reset, if_busy, mem_busy, ld_hazard, br_taken;
  logic [AW-1:0] br_addr, mem_pc, new_pc, epc;
  logic          mem_en, mem_exrt, mem_int_en_wr, mem_int_en_val, irq;
  logic [2:0]    mem_exp_code, exp_cause;
  logic          if_stall, id_stall, ex_stall, mem_stall;
  logic          if_flush, id_flush, ex_flush, mem_flush;
  logic          new_pc_vld, int_en;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .EXP_VEC(EV)) dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .br_taken(br_taken), .br_addr(br_addr),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
    .mem_exrt(mem_exrt), .mem_int_en_wr(mem_int_en_wr),
    .mem_int_en_val(mem_int_en_val), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
    .new_pc_vld(new_pc_vld), .epc(epc), .exp_cause(exp_cause), .int_en(int_en)
  );

  typedef struct {
    logic        rst, ifb, memb, ld, br;
    logic [29:0] br_addr;
    logic        en;
    logic [29:0] pc;
    logic [2:0]  code;
    logic        exrt, wr, val, irq;
  } stim_t;

  typedef struct {
    logic [3:0]  stall;   // {if,id,ex,mem}
    logic [3:0]  flush;   // {if,id,ex,mem}
    logic [29:0] npc;
    logic        npv;
    logic [29:0] epc;
    logic [2:0]  cause;
    logic        ie;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state: architectural values plus the irq samples seen at
  // the last two clock edges (oldest first; the oldest is what the core sees).
  bit          m_recover = 1'b0;
  logic [29:0] m_epc     = 30'd0;
  logic [2:0]  m_cause   = 3'd0;
  bit          m_ie      = 1'b0;
  bit          m_irq_hist[$] = '{1'b0, 1'b0};

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit   busy, exc, intr, ret;
    e.stall = 4'b0000; e.flush = 4'b0000; e.npc = 30'd0; e.npv = 1'b0;
    e.epc = m_epc; e.cause = m_cause; e.ie = m_ie;
    busy = s.ifb | s.memb;
    exc  = s.en && (s.code != 3'd0);
    intr = s.en && m_irq_hist[0] && m_ie;
    ret  = s.en && s.exrt;
    if (s.rst) return e;
    if (busy) begin
      e.stall = 4'b1111;
      return e;
    end
    if (m_recover) return e;
    if (exc || intr) begin
      e.flush = 4'b1111; e.npc = EV; e.npv = 1'b1;
    end else if (ret) begin
      e.flush = 4'b1111; e.npc = m_epc; e.npv = 1'b1;
    end else begin
      if (s.br) begin e.flush[3] = 1'b1; e.npc = s.br_addr; e.npv = 1'b1; end
      if (s.ld) begin e.stall[3] = 1'b1; e.flush[2] = 1'b1; end
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    bit busy, exc, intr, ret;
    busy = s.ifb | s.memb;
    exc  = s.en && (s.code != 3'd0);
    intr = s.en && m_irq_hist[0] && m_ie;
    ret  = s.en && s.exrt;
    if (s.rst) begin
      m_recover = 1'b0; m_epc = 30'd0; m_cause = 3'd0; m_ie = 1'b0;
      m_irq_hist = '{1'b0, 1'b0};
      return;
    end
    if (!busy) begin
      if (m_recover) m_recover = 1'b0;
      else if (exc) begin
        m_epc = s.pc; m_cause = s.code; m_ie = 1'b0; m_recover = 1'b1;
      end else if (intr) begin
        m_epc = s.pc; m_cause = 3'd1; m_ie = 1'b0; m_recover = 1'b1;
      end else if (ret) begin
        m_ie = 1'b1; m_recover = 1'b1;
      end else if (s.en && s.wr) m_ie = s.val;
    end
    void'(m_irq_hist.pop_front());
    m_irq_hist.push_back(s.irq);
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    reset = s.rst; if_busy = s.ifb; mem_busy = s.memb; ld_hazard = s.ld;
    br_taken = s.br; br_addr = s.br_addr; mem_en = s.en; mem_pc = s.pc;
    mem_exp_code = s.code; mem_exrt = s.exrt; mem_int_en_wr = s.wr;
    mem_int_en_val = s.val; irq = s.irq;
    sb_q.push_back(model_out(s));
    model_step(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.ifb = 1'b0; s.memb = 1'b0; s.ld = 1'b0; s.br = 1'b0;
    s.br_addr = 30'd0; s.en = 1'b0; s.pc = 30'd0; s.code = 3'd0;
    s.exrt = 1'b0; s.wr = 1'b0; s.val = 1'b0; s.irq = 1'b0;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  // Monitor: compares every queued expectation with the DUT on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      chk("stall", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'(e.stall));
      chk("flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'(e.flush));
      chk("new_pc_vld", 32'(new_pc_vld), 32'(e.npv));
      chk("new_pc", 32'(new_pc), 32'(e.npc));
      chk("epc", 32'(epc), 32'(e.epc));
      chk("exp_cause", 32'(exp_cause), 32'(e.cause));
      chk("int_en", 32'(int_en), 32'(e.ie));
    end
  end

  initial begin
    stim_t s;
    bit    irq_lvl;
    reset = 1'b1; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
    br_taken = 1'b0; br_addr = 30'd0; mem_en = 1'b0; mem_pc = 30'd0;
    mem_exp_code = 3'd0; mem_exrt = 1'b0; mem_int_en_wr = 1'b0;
    mem_int_en_val = 1'b0; irq = 1'b0;

    // Reset state
    s = idle(); s.rst = 1'b1;
    repeat (2) drive(s);
    s = idle(); s.en = 1'b1; s.code = 3'd3; s.br = 1'b1; s.ld = 1'b1;
    s.rst = 1'b1;
    drive(s);                          // events ignored under reset

    // Exception, then a further exception code in RECOVER is ignored
    s = idle(); s.en = 1'b1; s.code = 3'd3; s.pc = 30'h40; drive(s);
    s.code = 3'd5; s.pc = 30'h80; drive(s);
    drive(idle());

    // Return-from-exception to epc=0x40
    s = idle(); s.en = 1'b1; s.exrt = 1'b1; drive(s);
    drive(idle()); drive(idle());

    // Interrupt latency with int_en=1
    s = idle(); s.en = 1'b1; s.irq = 1'b1;
    repeat (4) drive(s);
    s.irq = 1'b0;
    repeat (3) drive(s);
    // irq with int_en=0 -> never taken
    s.irq = 1'b1;
    repeat (4) drive(s);
    s.irq = 1'b0;
    repeat (2) drive(s);

    // Priority: exception beats branch and load hazard
    s = idle(); s.en = 1'b1; s.code = 3'd2; s.br = 1'b1; s.ld = 1'b1;
    s.br_addr = 30'h123; s.pc = 30'h2A;
    drive(s);
    drive(idle());
    s = idle(); s.br = 1'b1; s.ld = 1'b1; s.br_addr = 30'h3ABC_DEF0; drive(s);
    s = idle(); s.ld = 1'b1; drive(s);

    // Busy deferral: pending exception held off by mem_busy for 3 cycles
    s = idle(); s.en = 1'b1; s.code = 3'd6; s.pc = 30'h77; s.memb = 1'b1;
    repeat (3) drive(s);
    s.memb = 1'b0; drive(s);
    s.ifb = 1'b1; repeat (2) drive(s); // RECOVER holds while busy
    s.ifb = 1'b0; drive(s);
    drive(idle());

    // Reset in the middle of RECOVER
    s = idle(); s.en = 1'b1; s.code = 3'd4; s.pc = 30'h55; drive(s);
    s = idle(); s.rst = 1'b1; drive(s);
    s = idle(); s.br = 1'b1; s.br_addr = 30'h10; drive(s);
    drive(idle());

    // Randomised traffic
    irq_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 10) irq_lvl = ~irq_lvl;
      s.rst     = ($urandom_range(0, 199) < 3);
      s.ifb     = ($urandom_range(0, 99) < 6);
      s.memb    = ($urandom_range(0, 99) < 10);
      s.ld      = ($urandom_range(0, 99) < 20);
      s.br      = ($urandom_range(0, 99) < 20);
      s.br_addr = 30'($urandom);
      s.en      = ($urandom_range(0, 99) < 75);
      s.pc      = 30'($urandom);
      s.code    = ($urandom_range(0, 99) < 10) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.exrt    = ($urandom_range(0, 99) < 8);
      s.wr      = ($urandom_range(0, 99) < 15);
      s.val     = ($urandom_range(0, 99) < 70);
      s.irq     = irq_lvl;
      drive(s);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 30, word-address width.
- EXP_VEC, 30'h0000_0100, exception handler word address.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_busy  in  1  fetch bus access not complete.
- mem_busy  in  1  data bus access not complete.
- ld_hazard  in  1  ID instruction consumes the load result of the instruction in EX.
- br_taken  in  1  ID resolved a taken branch.
- br_addr  in  ADDR_W  branch target.
- mem_en  in  1  MEM stage holds a valid instruction.
- mem_pc  in  ADDR_W  PC of the MEM instruction.
- mem_exp_code  in  3  MEM exception code; 0 = none, 1 reserved for the external interrupt.
- mem_exrt  in  1  MEM instruction is return-from-exception.
- mem_int_en_wr  in  1  MEM instruction writes the interrupt enable.
- mem_int_en_val  in  1  value for that write.
- irq  in  1  asynchronous external interrupt level.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  pipeline-register hold.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  pipeline-register bubble.
- new_pc  out  ADDR_W  redirect target.
- new_pc_vld  out  1  redirect fetch to new_pc this cycle.
- epc  out  ADDR_W  saved exception PC.
- exp_cause  out  3  saved exception code.
- int_en  out  1  interrupt enable.

Function
REQ-003 busy = if_busy | mem_busy; while busy=1, all four stall outputs SHALL be 1, all flush outputs and new_pc_vld SHALL be 0, and no register SHALL change except the irq synchronizer.
REQ-004 irq SHALL pass through a 2-flop synchronizer; irq_s is the second flop, so irq_s follows irq 2 cycles later.
REQ-005 State machine with states RUN and RECOVER; reset state is RUN.
REQ-006 In RUN with busy=0, events SHALL be evaluated in this fixed priority, highest first.
REQ-007 (a) Exception: mem_en=1 and mem_exp_code!=0.
- epc<=mem_pc; exp_cause<=mem_exp_code; int_en<=0.
- All four flushes = 1; new_pc=EXP_VEC; new_pc_vld=1; state<=RECOVER.
REQ-008 (b) Interrupt: mem_en=1, irq_s=1, int_en=1.
- Identical to (a) except exp_cause<=1.
REQ-009 (c) Return: mem_en=1 and mem_exrt=1.
- int_en<=1; all four flushes = 1; new_pc=epc; new_pc_vld=1; state<=RECOVER.
REQ-010 (d) Branch: br_taken=1.
- if_flush=1; new_pc=br_addr; new_pc_vld=1.
- Other flushes 0; state stays RUN.
REQ-011 (e) Load hazard: ld_hazard=1.
- if_stall=1; id_flush=1 (inserts a bubble into ID/EX).
- Other stalls and flushes 0.
REQ-012 Rules (d) and (e) SHALL apply together if both are active and no higher-priority event fires.
REQ-013 mem_int_en_wr with mem_en=1, busy=0 and no event (a)-(c) SHALL set int_en<=mem_int_en_val; (a)-(c) override it.
REQ-014 RECOVER SHALL last exactly one non-busy cycle, then return to RUN.
- All inputs except busy are ignored; outputs are 0 except stalls under busy.
- RECOVER SHALL hold while busy=1.
REQ-015 new_pc and new_pc_vld SHALL be combinational, valid in the detection cycle; epc, exp_cause, int_en and state SHALL be registered.
REQ-016 When new_pc_vld=0, new_pc SHALL be 0.

Reset
REQ-017 reset=1 at a clock edge SHALL set:
- state=RUN, epc=0, exp_cause=0, int_en=0, both synchronizer flops=0.
REQ-018 While reset=1, all stall, flush and new_pc_vld outputs SHALL be 0, new_pc SHALL be 0, and all events SHALL be ignored.
REQ-019 Reset asserted in RECOVER SHALL return the block to RUN on the same edge.

Verification
REQ-020 Exception: mem_en=1, mem_exp_code=3, mem_pc=30'h40, busy=0 -> same cycle all flushes=1, new_pc_vld=1, new_pc=30'h100; next cycle epc=30'h40, exp_cause=3, int_en=0, state RECOVER; a further exception code in RECOVER is ignored.
REQ-021 Interrupt latency: int_en=1, irq rises at cycle 0, mem_en=1 steady -> interrupt taken in cycle 2, exp_cause=1; with int_en=0 -> no redirect.
REQ-022 Priority: exception + br_taken + ld_hazard in the same cycle -> only exception behaviour, new_pc=EXP_VEC; br_taken + ld_hazard alone -> if_stall=1, if_flush=1, id_flush=1, new_pc=br_addr.
REQ-023 Busy deferral: mem_busy=1 for 3 cycles with a pending exception -> stalls=1, no flush or register change for 3 cycles; exception taken in cycle 4.
REQ-024 Return: epc=30'h40, mem_exrt=1 -> all flushes=1, new_pc=30'h40, new_pc_vld=1, next cycle int_en=1.
REQ-025 Reset mid-RECOVER -> next cycle state RUN, epc=0, int_en=0, all outputs 0.
